// File: rtl/key_capture_pkg.sv
// Shared types and helpers for the key capture front end:
// FSM state, key count, default debounce length, arbitration helpers.
package key_capture_pkg;

    localparam int unsigned NUM_KEYS         = 4;
    localparam int unsigned DEBOUNCE_DEFAULT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Highest index wins: key3 > key2 > key1 > key0.
    function automatic logic [NUM_KEYS-1:0] pick_winner(input logic [NUM_KEYS-1:0] req);
        logic [NUM_KEYS-1:0] win;
        win = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (req[i]) begin
                win    = '0;
                win[i] = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic is_multi_hot(input logic [NUM_KEYS-1:0] req);
        logic [NUM_KEYS-1:0] one;
        one = NUM_KEYS'(1);
        return (req & (req - one)) != '0;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key line: 2-flop synchroniser, consecutive-sample debounce counter
// and a one-cycle pulse on each accepted rising level.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic press
);

    localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          s_q;
    logic          db_q;
    logic          db_d;
    logic          db_dly_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The flip happens on the sample that completes the run, so the
    // counter only ever reaches DEBOUNCE_CYCLES-1 and never wraps.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = s_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= 1'b0;
            s_q      <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= key_in;
            s_q      <= meta_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
        end
    end

    assign press = db_q & ~db_dly_q;

endmodule

// File: rtl/key_onehot_capture.sv
// Four debounced key lines, fixed-priority arbitration and a registered
// one-hot capture register with valid/ack handshake and sticky overrun.
module key_onehot_capture
    import key_capture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic                ack,
    output logic [NUM_KEYS-1:0] onehot,
    output logic                valid,
    output logic                overrun
);

    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] winner;
    logic                any_press;
    logic                multi_press;

    state_e              state_q;
    logic [NUM_KEYS-1:0] onehot_q;
    logic                valid_q;
    logic                overrun_q;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .key_in(key_in[k]),
            .press (press[k])
        );
    end

    always_comb begin
        winner      = pick_winner(press);
        any_press   = |press;
        multi_press = is_multi_hot(press);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            onehot_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_press) begin
                        onehot_q  <= winner;
                        valid_q   <= 1'b1;
                        overrun_q <= overrun_q | multi_press;
                        state_q   <= HOLD;
                    end
                end
                HOLD: begin
                    if (!ack) begin
                        if (any_press) begin
                            overrun_q <= 1'b1;
                        end
                    end else if (any_press) begin
                        // ack and a new press on the same edge: hand over directly
                        onehot_q  <= winner;
                        overrun_q <= multi_press;
                    end else begin
                        onehot_q  <= '0;
                        valid_q   <= 1'b0;
                        overrun_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    onehot_q <= '0;
                    valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign onehot  = onehot_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_key_onehot_capture.sv
// Directed bench for key_onehot_capture with DEBOUNCE_CYCLES of 4 (default), 1 and 16.
module tb_key_onehot_capture;

    logic       clk;
    logic       rst_n;

    logic [3:0] key4,  key1,  key16;
    logic       ack4,  ack1,  ack16;
    logic [3:0] oh4,   oh1,   oh16;
    logic       val4,  val1,  val16;
    logic       ovr4,  ovr1,  ovr16;

    int errors;
    int checks;

    key_onehot_capture u_dut4 (
        .clk(clk), .rst_n(rst_n), .key_in(key4), .ack(ack4),
        .onehot(oh4), .valid(val4), .overrun(ovr4)
    );

    key_onehot_capture #(.DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .key_in(key1), .ack(ack1),
        .onehot(oh1), .valid(val1), .overrun(ovr1)
    );

    key_onehot_capture #(.DEBOUNCE_CYCLES(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .key_in(key16), .ack(ack16),
        .onehot(oh16), .valid(val16), .overrun(ovr16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack4();
        ack4 = 1'b1;
        step(1);
        ack4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        checks++; if (oh4 !== 4'b0000) begin errors++; $display("FAIL reset_onehot got=%b exp=0000", oh4); end
        checks++; if (val4 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", val4); end
        checks++; if (ovr4 !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", ovr4); end
        rst_n = 1'b1;
        step(2);

        // reset in the middle of key2's debounce, key held through release
        key4 = 4'b0100;
        step(3);
        rst_n = 1'b0;
        #1;
        checks++; if (val4 !== 1'b0 || oh4 !== 4'b0000) begin errors++; $display("FAIL reset_mid_debounce got=%b/%b exp=0/0000", val4, oh4); end
        step(2);
        rst_n = 1'b1;
        step(6);
        checks++; if (val4 !== 1'b0) begin errors++; $display("FAIL reset_redebounce_early got=%b exp=0", val4); end
        step(1);
        checks++; if (val4 !== 1'b1 || oh4 !== 4'b0100) begin errors++; $display("FAIL reset_redebounce_event got=%b/%b exp=1/0100", val4, oh4); end

        // reset while holding a code
        rst_n = 1'b0;
        #1;
        checks++; if (val4 !== 1'b0 || oh4 !== 4'b0000 || ovr4 !== 1'b0) begin errors++; $display("FAIL reset_in_hold got=%b/%b/%b exp=0/0000/0", val4, oh4, ovr4); end
        key4 = 4'b0000;
        step(1);
        rst_n = 1'b1;
        step(10);
        checks++; if (val4 !== 1'b0) begin errors++; $display("FAIL reset_quiet_after got=%b exp=0", val4); end
    endtask

    task automatic test_single_press();
        logic [1:0] enc;
        key4 = 4'b0010;
        step(6);
        checks++; if (val4 !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", val4); end
        step(1);
        checks++; if (val4 !== 1'b1 || oh4 !== 4'b0010) begin errors++; $display("FAIL single_latency got=%b/%b exp=1/0010", val4, oh4); end
        enc = {oh4[3] | oh4[2], oh4[3] | oh4[1]};
        checks++; if (enc !== 2'b01) begin errors++; $display("FAIL single_encoder got=%b exp=01", enc); end
        step(3);
        checks++; if (val4 !== 1'b1 || oh4 !== 4'b0010) begin errors++; $display("FAIL single_hold got=%b/%b exp=1/0010", val4, oh4); end
        pulse_ack4();
        checks++; if (val4 !== 1'b0 || oh4 !== 4'b0000) begin errors++; $display("FAIL single_ack got=%b/%b exp=0/0000", val4, oh4); end
        key4 = 4'b0000;
        step(10);
        checks++; if (val4 !== 1'b0) begin errors++; $display("FAIL single_release_event got=%b exp=0", val4); end
    endtask

    task automatic test_bounce();
        logic [4:0] pattern;
        pattern = 5'b01101; // LSB first: 1,0,1,1,0
        for (int i = 0; i < 5; i++) begin
            key4 = {3'b000, pattern[i]};
            step(1);
        end
        key4 = 4'b0001;
        step(6);
        checks++; if (val4 !== 1'b0) begin errors++; $display("FAIL bounce_early got=%b exp=0", val4); end
        step(1);
        checks++; if (val4 !== 1'b1 || oh4 !== 4'b0001 || ovr4 !== 1'b0) begin errors++; $display("FAIL bounce_event got=%b/%b/%b exp=1/0001/0", val4, oh4, ovr4); end
        pulse_ack4();
        step(10);
        checks++; if (val4 !== 1'b0) begin errors++; $display("FAIL bounce_single_event got=%b exp=0", val4); end
        key4 = 4'b0000;
        step(10);
    endtask

    task automatic test_simultaneous();
        key4 = 4'b0101;
        step(7);
        checks++; if (val4 !== 1'b1 || oh4 !== 4'b0100) begin errors++; $display("FAIL simul_winner got=%b/%b exp=1/0100", val4, oh4); end
        checks++; if (ovr4 !== 1'b1) begin errors++; $display("FAIL simul_overrun got=%b exp=1", ovr4); end
        pulse_ack4();
        checks++; if (val4 !== 1'b0 || ovr4 !== 1'b0 || oh4 !== 4'b0000) begin errors++; $display("FAIL simul_ack got=%b/%b/%b exp=0/0/0000", val4, ovr4, oh4); end
        step(10);
        checks++; if (val4 !== 1'b0) begin errors++; $display("FAIL simul_no_key0 got=%b exp=0", val4); end
        key4 = 4'b0000;
        step(10);
    endtask

    task automatic test_back_to_back();
        key4 = 4'b1000;
        step(7);
        checks++; if (val4 !== 1'b1 || oh4 !== 4'b1000) begin errors++; $display("FAIL hold_first got=%b/%b exp=1/1000", val4, oh4); end
        key4 = 4'b1010;
        step(8);
        checks++; if (oh4 !== 4'b1000 || ovr4 !== 1'b1 || val4 !== 1'b1) begin errors++; $display("FAIL hold_dropped got=%b/%b/%b exp=1000/1/1", oh4, ovr4, val4); end
        key4 = 4'b1000;
        step(8);
        key4 = 4'b1010;
        step(6);
        ack4 = 1'b1;     // sampled on the edge where key1's press pulse is seen
        step(1);
        ack4 = 1'b0;
        checks++; if (oh4 !== 4'b0010 || val4 !== 1'b1 || ovr4 !== 1'b0) begin errors++; $display("FAIL b2b_handover got=%b/%b/%b exp=0010/1/0", oh4, val4, ovr4); end
        pulse_ack4();
        checks++; if (val4 !== 1'b0 || oh4 !== 4'b0000) begin errors++; $display("FAIL b2b_final_ack got=%b/%b exp=0/0000", val4, oh4); end
        key4 = 4'b0000;
        step(10);
    endtask

    task automatic test_param_sweep();
        key1 = 4'b0001;
        step(3);
        checks++; if (val1 !== 1'b0) begin errors++; $display("FAIL d1_early got=%b exp=0", val1); end
        step(1);
        checks++; if (val1 !== 1'b1 || oh1 !== 4'b0001) begin errors++; $display("FAIL d1_latency got=%b/%b exp=1/0001", val1, oh1); end
        key1 = 4'b0000;

        key16 = 4'b1000;
        step(18);
        checks++; if (val16 !== 1'b0) begin errors++; $display("FAIL d16_early got=%b exp=0", val16); end
        step(1);
        checks++; if (val16 !== 1'b1 || oh16 !== 4'b1000) begin errors++; $display("FAIL d16_latency got=%b/%b exp=1/1000", val16, oh16); end
        ack16 = 1'b1;
        step(1);
        ack16 = 1'b0;
        key16 = 4'b0000;
        step(25);
        // a 10-sample glitch is shorter than 16 and must be filtered
        key16 = 4'b0001;
        step(10);
        key16 = 4'b0000;
        step(30);
        checks++; if (val16 !== 1'b0) begin errors++; $display("FAIL d16_filter got=%b exp=0", val16); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        key4   = '0; key1 = '0; key16 = '0;
        ack4   = 1'b0; ack1 = 1'b0; ack16 = 1'b0;

        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_back_to_back();
        test_param_sweep();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
